// File: rtl/pixel_frame_sequencer.sv
// Streams one IMG_W x IMG_H frame src RAM -> pixel unit -> dst RAM, same address; config latched at start.
// Latency: write of address a lands 2 cycles after its read, 1 pixel/clk; no backpressure, abort drops in-flight pixels.
module pixel_frame_sequencer #(
    parameter int IMG_W  = 256,
    parameter int IMG_H  = 256,
    parameter int ADDR_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              abort,
    input  logic [2:0]        cfg_oper,
    input  logic [7:0]        cfg_value,
    input  logic [7:0]        cfg_threshold,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [23:0]       rd_data,
    output logic [2:0]        select_oper,
    output logic [7:0]        value,
    output logic [7:0]        threshold,
    output logic              done_in,
    output logic [7:0]        red_in,
    output logic [7:0]        green_in,
    output logic [7:0]        blue_in,
    input  logic              done_out,
    input  logic [7:0]        red_out,
    input  logic [7:0]        green_out,
    input  logic [7:0]        blue_out,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [23:0]       wr_data,
    output logic              busy,
    output logic              frame_done
);

    localparam int N = IMG_W * IMG_H;
    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(N - 1);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t state, state_nxt;
    logic   launch;

    assign launch     = (state == IDLE) && start;
    assign rd_en      = (state == RUN);
    assign busy       = (state == RUN) || (state == DRAIN);
    assign frame_done = (state == DONE);
    // Gating with busy drops results still in the pixel pipe after an abort.
    assign wr_en      = done_out && busy;

    assign red_in   = rd_data[23:16];
    assign green_in = rd_data[15:8];
    assign blue_in  = rd_data[7:0];
    assign wr_data  = {red_out, green_out, blue_out};

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = RUN;
            RUN:     if (rd_addr == LAST) state_nxt = DRAIN;
            DRAIN:   if (wr_en && (wr_addr == LAST)) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        if (abort && (state != IDLE)) state_nxt = IDLE;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            done_in     <= 1'b0;
            rd_addr     <= '0;
            wr_addr     <= '0;
            select_oper <= '0;
            value       <= '0;
            threshold   <= '0;
        end else begin
            state   <= state_nxt;
            done_in <= rd_en && !abort;
            if (launch) begin
                select_oper <= cfg_oper;
                value       <= cfg_value;
                threshold   <= cfg_threshold;
                rd_addr     <= '0;
                wr_addr     <= '0;
            end else begin
                // Both counters stop at the last pixel rather than wrapping.
                if (rd_en && (rd_addr != LAST)) rd_addr <= rd_addr + 1'b1;
                if (wr_en && (wr_addr != LAST)) wr_addr <= wr_addr + 1'b1;
            end
        end
    end

endmodule
